// File: rtl/mlp_pkg.sv
// Shared sizes and types for the mlp_98 frame scheduler.
package mlp_pkg;
  localparam int N1    = 98;
  localparam int N2    = 20;
  localparam int W_X   = 4;
  localparam int W_K   = 4;
  localparam int LANES = N1 / 2;
  localparam int W_Y   = W_X + 2 * W_K + $clog2(LANES) + $clog2(N2);
  localparam int W_IDX = $clog2(LANES);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HOLD = 2'd2} sched_state_t;

  typedef struct packed {
    logic [W_X-1:0] mag;
    logic           pol;
  } lane_t;
endpackage

// File: rtl/mlp_frame_loader.sv
// Frame assembly: lane index, per-lane sample registers and frame-length error flag.
module mlp_frame_loader
  import mlp_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       beat,
  input  logic [W_X-1:0]             s_mag,
  input  logic                       s_pol,
  input  logic                       s_last,
  input  logic                       err_clr,
  output logic                       at_end,
  output logic                       done,
  output logic                       err_len,
  output logic [LANES-1:0][W_X-1:0]  lane_mag,
  output logic [LANES-1:0]           lane_pol
);
  logic [W_IDX-1:0] idx;
  logic             err_set;
  lane_t            frame_q [LANES];

  assign at_end  = (idx == W_IDX'(LANES - 1));
  assign done    = beat & at_end;
  // Length error: last lane without s_last, or s_last before the last lane.
  assign err_set = beat & (at_end ^ s_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx     <= '0;
      err_len <= 1'b0;
    end else begin
      if (beat) idx <= (at_end || s_last) ? '0 : idx + 1'b1;
      err_len <= err_set | (err_len & ~err_clr);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) frame_q[l] <= '0;
      else if (beat && idx == W_IDX'(l)) frame_q[l] <= '{mag: s_mag, pol: s_pol};
    end
    assign lane_mag[l] = frame_q[l].mag;
    assign lane_pol[l] = frame_q[l].pol;
  end
endmodule

// File: rtl/mlp_98_sched.sv
// Frame scheduler for mlp_98: loads a frame, waits LAT cycles, holds the result.
// Optional MLP_SCHED_OVERLAP_EN: load the next frame while the result waits in HOLD.
module mlp_98_sched
  import mlp_pkg::*;
#(
  parameter int LAT = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [W_X-1:0]         s_mag,
  input  logic                   s_pol,
  input  logic                   s_last,
  output logic [LANES*W_X-1:0]   mlp_in_mag,
  output logic [LANES-1:0]       mlp_in_pol,
  input  logic [W_Y-1:0]         mlp_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [W_Y-1:0]         m_data,
  output logic                   busy,
  output logic                   err_len,
  input  logic                   err_clr
);
  localparam int W_CNT = (LAT > 1) ? $clog2(LAT) : 1;

  sched_state_t             state, state_d;
  logic [W_CNT-1:0]         cnt;
  logic                     cnt_done, beat, at_end, done;
  logic [LANES-1:0][W_X-1:0] lane_mag;

  assign cnt_done   = (cnt == W_CNT'(LAT - 1));
  assign beat       = s_valid & s_ready;
  assign busy       = (state != LOAD);
  assign mlp_in_mag = lane_mag;

  always_comb begin
    s_ready = 1'b0;
`ifdef MLP_SCHED_OVERLAP_EN
    // Final lane only enters alongside the result handshake, so RUN never overlaps HOLD.
    case (state)
      LOAD:    s_ready = 1'b1;
      HOLD:    s_ready = at_end ? m_ready : 1'b1;
      default: s_ready = 1'b0;
    endcase
`else
    s_ready = (state == LOAD);
`endif
  end

  mlp_frame_loader u_loader (
    .clk      (clk),
    .rstn     (rstn),
    .beat     (beat),
    .s_mag    (s_mag),
    .s_pol    (s_pol),
    .s_last   (s_last),
    .err_clr  (err_clr),
    .at_end   (at_end),
    .done     (done),
    .err_len  (err_len),
    .lane_mag (lane_mag),
    .lane_pol (mlp_in_pol)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= LOAD;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      LOAD: if (done) state_d = RUN;
      RUN:  if (cnt_done) state_d = HOLD;
      HOLD: begin
        if (m_ready) begin
`ifdef MLP_SCHED_OVERLAP_EN
          state_d = done ? RUN : LOAD;
`else
          state_d = LOAD;
`endif
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      cnt <= (state == RUN) ? cnt + 1'b1 : '0;
      if (state == RUN && cnt_done) begin
        m_valid <= 1'b1;
        m_data  <= mlp_out;
      end else if (state == HOLD && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mlp_98_sched.sv
// Directed bench for mlp_98_sched; covers MLP_SCHED_OVERLAP_EN when defined.
module tb_mlp_98_sched;
  import mlp_pkg::*;

  logic                 clk = 0, rstn = 0;
  logic                 s_valid = 0, s_pol = 0, s_last = 0, m_ready = 0, err_clr = 0;
  logic [W_X-1:0]       s_mag = '0;
  logic [W_Y-1:0]       mlp_out = '0;
  logic                 s_ready, m_valid, busy, err_len;
  logic [LANES*W_X-1:0] mlp_in_mag;
  logic [LANES-1:0]     mlp_in_pol;
  logic [W_Y-1:0]       m_data;
  int checks = 0, errors = 0;

`ifdef MLP_SCHED_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  mlp_98_sched #(.LAT(8)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_mag(s_mag),
    .s_pol(s_pol), .s_last(s_last), .mlp_in_mag(mlp_in_mag), .mlp_in_pol(mlp_in_pol),
    .mlp_out(mlp_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .err_len(err_len), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [W_X-1:0] lmag(input int l);
    return mlp_in_mag[l*W_X +: W_X];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic beat(input logic [W_X-1:0] mag, input logic pol, input logic last);
    int n = 0;
    s_valid = 1; s_mag = mag; s_pol = pol; s_last = last;
    #1;
    while (!s_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout s_ready=%b want 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_frame(input int n, input int off, input int last_at);
    for (int i = 0; i < n; i++) beat(W_X'((i + off) % 16), i[0], i == last_at);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake();
    m_ready = 1; @(posedge clk); #1; m_ready = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
    checks++; if ({busy, err_len} !== 2'b00) begin errors++; $display("FAIL reset_busy_err got %b want 00", {busy, err_len}); end
    checks++; if (mlp_in_mag !== '0 || mlp_in_pol !== '0) begin errors++; $display("FAIL reset_frame got nonzero want 0"); end
  endtask

  task automatic test_nominal();
    int lat;
    mlp_out = 23'h1234;
    send_frame(49, 0, 48);
    checks++; if ({busy, s_ready} !== 2'b10) begin errors++; $display("FAIL nom_run_flags got %b want 10", {busy, s_ready}); end
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL nom_latency got %0d want 8", lat); end
    checks++; if (m_data !== 23'h1234) begin errors++; $display("FAIL nom_m_data got %h want 1234", m_data); end
    checks++; if (lmag(0) !== 4'd0 || lmag(48) !== 4'd0) begin errors++; $display("FAIL nom_lane0_48 got %h/%h want 0/0", lmag(0), lmag(48)); end
    checks++; if (lmag(17) !== 4'd1 || mlp_in_pol[17] !== 1'b1 || mlp_in_pol[48] !== 1'b0) begin
      errors++; $display("FAIL nom_lane17 got %h pol17 %b pol48 %b want 1 1 0", lmag(17), mlp_in_pol[17], mlp_in_pol[48]);
    end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL nom_err_len got %b want 0", err_len); end
    mlp_out = 23'h7ffff;
  endtask

  task automatic test_backpressure();
    logic [W_Y+2:0] exp;
    exp = {1'b1, 1'b1, OVL, 23'h1234};
    m_ready = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({m_valid, busy, s_ready, m_data} !== exp) begin
        errors++; $display("FAIL bp_hold cyc %0d got v%b b%b r%b %h want v1 b1 r%b 1234", c, m_valid, busy, s_ready, m_data, OVL);
      end
    end
    handshake();
    checks++; if ({m_valid, s_ready, busy} !== 3'b010) begin errors++; $display("FAIL bp_release got %b want 010", {m_valid, s_ready, busy}); end
  endtask

  task automatic test_short();
    int lat, nres;
    send_frame(11, 0, 10);
    checks++; if ({err_len, busy, s_ready} !== 3'b101) begin errors++; $display("FAIL short_err got %b want 101", {err_len, busy, s_ready}); end
    mlp_out = 23'h0abcd;
    send_frame(49, 5, 48);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL short_next_latency got %0d want 8", lat); end
    checks++; if (m_data !== 23'h0abcd || err_len !== 1'b1) begin errors++; $display("FAIL short_next_data got %h err %b want 0abcd 1", m_data, err_len); end
    checks++; if (lmag(0) !== 4'd5) begin errors++; $display("FAIL short_next_lane0 got %h want 5", lmag(0)); end
    handshake();
    nres = 0;
    repeat (15) begin @(posedge clk); #1; if (m_valid) nres++; end
    checks++; if (nres !== 0) begin errors++; $display("FAIL short_extra_result got %0d want 0", nres); end
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", err_len); end
    err_clr = 1;
    beat(4'd3, 1'b0, 1'b1);
    err_clr = 0;
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", err_len); end
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL err_clr2 got %b want 0", err_len); end
  endtask

  task automatic test_missing_last();
    int lat;
    mlp_out = 23'h00321;
    send_frame(49, 3, -1);
    checks++; if ({busy, err_len} !== 2'b11) begin errors++; $display("FAIL miss_fire got %b want 11", {busy, err_len}); end
    wait_valid(lat);
    checks++; if (lat !== 8 || m_data !== 23'h00321) begin errors++; $display("FAIL miss_result got lat %0d %h want 8 00321", lat, m_data); end
    handshake();
    beat(4'hA, 1'b1, 1'b0);
    checks++; if (lmag(0) !== 4'hA || mlp_in_pol[0] !== 1'b1 || lmag(1) !== 4'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL miss_beat50 got %h %b %h busy %b want a 1 4 0", lmag(0), mlp_in_pol[0], lmag(1), busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    for (int i = 1; i < 49; i++) beat(W_X'(i % 16), i[0], i == 48);
    checks++; if ({busy, err_len} !== 2'b11) begin errors++; $display("FAIL rst_pre_run got %b want 11", {busy, err_len}); end
    repeat (3) @(posedge clk);
    #1 rstn = 0;
    #1;
    checks++; if ({m_valid, err_len, busy, s_ready} !== 4'b0001) begin
      errors++; $display("FAIL rst_async got %b want 0001", {m_valid, err_len, busy, s_ready});
    end
    checks++; if (mlp_in_mag !== '0) begin errors++; $display("FAIL rst_frame got nonzero want 0"); end
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_s_ready got %b want 1", s_ready); end
    mlp_out = 23'h5a5a5;
    send_frame(49, 7, 48);
    wait_valid(lat);
    checks++; if (lat !== 8 || m_data !== 23'h5a5a5 || err_len !== 1'b0) begin
      errors++; $display("FAIL rst_fresh got lat %0d %h err %b want 8 5a5a5 0", lat, m_data, err_len);
    end
    handshake();
  endtask

  task automatic test_overlap();
    int lat;
    mlp_out = 23'h11111;
    send_frame(49, 0, 48);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ovl_first_latency got %0d want 8", lat); end
    send_frame(48, 2, -1);
    checks++; if ({m_valid, busy} !== 2'b11) begin errors++; $display("FAIL ovl_hold_load got %b want 11", {m_valid, busy}); end
    s_valid = 1; s_mag = 4'd2; s_pol = 1'b0; s_last = 1; #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ovl_final_blocked got %b want 0", s_ready); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovl_still_valid got %b want 1", m_valid); end
    mlp_out = 23'h22222;
    m_ready = 1; #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ovl_final_ready got %b want 1", s_ready); end
    @(posedge clk); #1;
    m_ready = 0; s_valid = 0; s_last = 0;
    checks++; if ({m_valid, busy, s_ready, err_len} !== 4'b0100) begin
      errors++; $display("FAIL ovl_dual_hs got %b want 0100", {m_valid, busy, s_ready, err_len});
    end
    checks++; if (lmag(0) !== 4'd2 || lmag(47) !== 4'd1 || lmag(48) !== 4'd2) begin
      errors++; $display("FAIL ovl_lanes got %h %h %h want 2 1 2", lmag(0), lmag(47), lmag(48));
    end
    wait_valid(lat);
    checks++; if (lat !== 8 || m_data !== 23'h22222) begin errors++; $display("FAIL ovl_second got lat %0d %h want 8 22222", lat, m_data); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_short();
    test_missing_last();
    test_reset_mid_run();
    if (OVL) test_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlp_98_sched.md
Name: mlp_98_sched

Overview:
- Frame scheduler/controller for the 98-input, 20-hidden MLP datapath (mlp_98).
- Accepts a serial stream of sign-magnitude samples (one per beat), assembles N1/2 = 49 lanes into a frame and holds the frame stable on the datapath inputs.
- Waits a fixed datapath latency, captures the scalar MLP output and presents it downstream with valid/ready.
- Sits between the sample-ingest stream and the mlp_98 instance.

Parameters:
- N1, 98, MLP input count; lanes = N1/2.
- N2, 20, hidden width; used only for output width.
- W_X, 4, input magnitude width.
- W_K, 4, weight width; used only for output width.
- LAT, 8, datapath latency in cycles from frame-stable to output-valid; must be >= 1.
- W_Y, W_X+2*W_K+$clog2(N1/2)+$clog2(N2) = 23, MLP output width.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  sample beat valid
- s_ready  out  1  sample beat ready
- s_mag  in  W_X  sample magnitude
- s_pol  in  1  sample polarity
- s_last  in  1  marks final beat of a frame
- mlp_in_mag  out  (N1/2)*W_X  frame magnitudes to datapath; lane 0 = first beat
- mlp_in_pol  out  N1/2  frame polarities to datapath
- mlp_out  in  W_Y  datapath result
- m_valid  out  1  result valid
- m_ready  in  1  result ready
- m_data  out  W_Y  captured result
- busy  out  1  high in RUN or HOLD
- err_len  out  1  sticky frame-length error
- err_clr  in  1  clears err_len (synchronous pulse)

Behaviour:
- Reset (async assert, sync-clean deassert on clk): state=LOAD, idx=0, cnt=0, frame regs=0, m_valid=0, m_data=0, err_len=0. s_ready=1 in the first cycle after reset. A reset mid-frame or mid-RUN discards all work.
- Beat handshake occurs on s_valid & s_ready. Result handshake occurs on m_valid & m_ready.
- LOAD (s_ready=1):
  - Each beat writes {s_mag, s_pol} to lane idx, then idx++.
  - Beat with idx==N1/2-1 → lane written, idx=0, cnt=0, go RUN. If s_last=0 on this beat, set err_len; the frame still fires.
  - Beat with s_last=1 and idx<N1/2-1 → set err_len, discard the partial frame, idx=0, stay LOAD.
- RUN (s_ready=0):
  - mlp_in_* held constant. cnt increments each cycle.
  - At cnt==LAT-1: m_data<=mlp_out, m_valid<=1, go HOLD.
  - m_valid therefore rises exactly LAT cycles after the last-beat acceptance edge.
- HOLD:
  - m_valid=1 and m_data stable until m_ready.
  - On handshake: m_valid<=0, go LOAD.
  - s_ready=0 in HOLD (base build).
- err_len:
  - Sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, the set wins.
- busy = (state != LOAD).
- Frame registers are only written in LOAD (or in HOLD with the optional feature). They are never written in RUN.

Optional Feature:
- Macro: MLP_SCHED_OVERLAP_EN.
- Defined:
  - In HOLD, s_ready=1 for idx < N1/2-1, so lanes 0..47 of the next frame load while the result waits. This is safe because the output is already captured.
  - The final beat (idx==N1/2-1) is accepted only when m_ready=1 in the same cycle: s_ready = m_ready on that beat.
  - Simultaneous result handshake and final-beat acceptance → go directly to RUN with cnt=0.
  - Result handshake without the final beat → go LOAD with idx preserved.
  - Error rules are unchanged.
- Undefined: behaviour exactly as the base build.

Decomposition:
- Package mlp_pkg holds:
  - localparams N1, N2, W_X, W_K, LANES=N1/2, W_Y.
  - state enum typedef sched_state_t {LOAD, RUN, HOLD}.
  - lane typedef struct {mag, pol}.
- One natural sub-module: mlp_frame_loader (idx counter, lane write enables, s_last checking, error generation). The FSM, latency counter and output register stay in the top module.

Test Plan:
- Nominal frame: reset, send 49 beats (mag=i%16, pol=i[0], s_last on beat 48); stub mlp_out=23'h1234 → m_valid rises 8 cycles after beat 48; m_data=0x1234; mlp_in_mag lane 0=0, lane 48=0.
- Backpressure: hold m_ready=0 for 20 cycles → m_valid and m_data stable, s_ready=0, busy=1 throughout. Assert m_ready → m_valid=0 and s_ready=1 next cycle.
- Short frame: s_last on beat 10 → err_len=1, idx reset, no RUN. A following 49-beat frame produces exactly one result. Pulse err_clr → err_len=0.
- Missing s_last: 49 beats with s_last=0 → frame fires and err_len=1. Beat 50 is captured as lane 0 of the next frame.
- Reset mid-RUN: assert rstn=0 at cnt=3 → m_valid=0 and err_len=0 immediately. After release, s_ready=1 and a fresh frame completes normally.
- With MLP_SCHED_OVERLAP_EN:
  - Load 48 beats during HOLD; present beat 48 with m_ready=0 → s_ready=0.
  - Raise m_ready → both handshakes in one cycle, RUN entered, next m_valid 8 cycles later.
